// File: rtl/bf_io_responder.sv
// I/O responder for the core's req/ack bus: ',' reads pop an RX byte FIFO, '.' writes push a TX byte FIFO.
// Optional feature macro BF_IO_EOF_EN adds the rx_eof port so reads on an empty RX complete with EOF_VALUE.
module bf_io_responder #(
  parameter int         DEPTH_LOG2 = 4,
  parameter int         ACK_DELAY  = 0,
  parameter logic [7:0] EOF_VALUE  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_req,
  input  logic                  io_dir,
  input  logic [7:0]            io_wdata,
  output logic                  io_ack,
  output logic [7:0]            io_rdata,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
`ifdef BF_IO_EOF_EN
  input  logic                  rx_eof,
`endif
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic [DEPTH_LOG2:0]   tx_level
);

  localparam int                 DEPTH    = 1 << DEPTH_LOG2;
  localparam int                 LVL_W    = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(DEPTH);
  localparam logic [3:0]         DLY_LAST = 4'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
  localparam logic               DIR_WRITE = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SERVE, S_ACK} state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_dly_cnt;
  logic                    w_rx_pop, w_tx_push, w_ack_set, w_ack_clr, w_eof;

  logic [7:0]              r_rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_rx_wr, r_rx_rd;
  logic [LVL_W-1:0]        r_rx_level;
  logic                    w_rx_push, w_rx_empty;

  logic [7:0]              r_tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_tx_wr, r_tx_rd;
  logic [LVL_W-1:0]        r_tx_level;
  logic                    w_tx_pop, w_tx_full;

`ifdef BF_IO_EOF_EN
  assign w_eof = rx_eof;
`else
  assign w_eof = 1'b0;
`endif

  assign rx_ready   = (r_rx_level != FULL_LVL);
  assign w_rx_empty = (r_rx_level == '0);
  assign w_rx_push  = rx_valid && rx_ready;
  assign tx_valid   = (r_tx_level != '0);
  assign w_tx_full  = (r_tx_level == FULL_LVL);
  assign w_tx_pop   = tx_valid && tx_ready;
  assign tx_data    = r_tx_mem[r_tx_rd];
  assign rx_level   = r_rx_level;
  assign tx_level   = r_tx_level;

  always_comb begin
    w_state_nxt = r_state;
    w_rx_pop    = 1'b0;
    w_tx_push   = 1'b0;
    w_ack_set   = 1'b0;
    w_ack_clr   = 1'b0;
    case (r_state)
      S_IDLE:  if (io_req) w_state_nxt = (ACK_DELAY > 0) ? S_DELAY : S_SERVE;
      S_DELAY: if (r_dly_cnt == DLY_LAST) w_state_nxt = S_SERVE;
      S_SERVE: begin
        if (io_dir == DIR_WRITE) begin
          if (!w_tx_full) begin
            w_tx_push   = 1'b1;
            w_ack_set   = 1'b1;
            w_state_nxt = S_ACK;
          end
        end else if (!w_rx_empty) begin
          w_rx_pop    = 1'b1;
          w_ack_set   = 1'b1;
          w_state_nxt = S_ACK;
        end else if (w_eof) begin
          w_ack_set   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!io_req) begin
          w_ack_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dly_cnt <= '0;
      io_ack    <= 1'b0;
      io_rdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dly_cnt <= (r_state == S_DELAY) ? r_dly_cnt + 4'd1 : 4'd0;
      if (w_ack_set)      io_ack <= 1'b1;
      else if (w_ack_clr) io_ack <= 1'b0;
      // A read that completes on an empty RX can only be the EOF case
      if (w_ack_set && io_dir != DIR_WRITE)
        io_rdata <= w_rx_empty ? EOF_VALUE : r_rx_mem[r_rx_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= io_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_level <= '0;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_level <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      r_rx_level <= r_rx_level + LVL_W'(w_rx_push) - LVL_W'(w_rx_pop);
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      r_tx_level <= r_tx_level + LVL_W'(w_tx_push) - LVL_W'(w_tx_pop);
    end
  end

endmodule

// File: tb/tb_bf_io_responder.sv
// Bench for bf_io_responder: one instance with ACK_DELAY=0, one with ACK_DELAY=3, queue scoreboards per FIFO.
module tb_bf_io_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       io_req, io_dir, io_ack;
  logic [7:0] io_wdata, io_rdata;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;
  logic [4:0] rx_level, tx_level;
`ifdef BF_IO_EOF_EN
  logic       rx_eof;
  logic       d_rx_eof;
`endif

  logic       d_req, d_dir, d_ack;
  logic [7:0] d_wdata, d_rdata;
  logic       d_rxv, d_rxr, d_txv, d_txr;
  logic [7:0] d_rxd, d_txd;
  logic [4:0] d_rxl, d_txl;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] d_q[$];

  always #5 clk = ~clk;

  bf_io_responder #(.DEPTH_LOG2(4), .ACK_DELAY(0), .EOF_VALUE(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
`ifdef BF_IO_EOF_EN
    .rx_eof(rx_eof),
`endif
    .rx_level(rx_level), .tx_level(tx_level));

  bf_io_responder #(.DEPTH_LOG2(4), .ACK_DELAY(3), .EOF_VALUE(8'h00)) u_dly (
    .clk(clk), .rst_n(rst_n), .io_req(d_req), .io_dir(d_dir), .io_wdata(d_wdata),
    .io_ack(d_ack), .io_rdata(d_rdata), .rx_valid(d_rxv), .rx_data(d_rxd),
    .rx_ready(d_rxr), .tx_valid(d_txv), .tx_data(d_txd), .tx_ready(d_txr),
`ifdef BF_IO_EOF_EN
    .rx_eof(d_rx_eof),
`endif
    .rx_level(d_rxl), .tx_level(d_txl));

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic core_xfer(input logic dir, input logic [7:0] wd, input int max_cyc,
                           output int ncyc);
    @(negedge clk);
    io_req   = 1'b1;
    io_dir   = dir;
    io_wdata = wd;
    ncyc     = 0;
    while (!io_ack && ncyc < max_cyc) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic core_release(output logic dropped);
    io_req = 1'b0;
    @(negedge clk);
    dropped = !io_ack;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (io_ack !== 1'b0)   begin n_errors++; $display("FAIL reset_ack got %b want 0", io_ack); end
    if (io_rdata !== 8'h0) begin n_errors++; $display("FAIL reset_rdata got %h want 00", io_rdata); end
    if (rx_level !== 5'd0) begin n_errors++; $display("FAIL reset_rxl got %0d want 0", rx_level); end
    if (tx_level !== 5'd0) begin n_errors++; $display("FAIL reset_txl got %0d want 0", tx_level); end
    if (rx_ready !== 1'b1) begin n_errors++; $display("FAIL reset_rxr got %b want 1", rx_ready); end
    if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_txv got %b want 0", tx_valid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    int n; logic dr; logic [7:0] exp;
    host_push(8'h41);
    n_checks++;
    if (rx_level !== 5'd1) begin n_errors++; $display("FAIL read_rxl_pre got %0d want 1", rx_level); end
    core_xfer(1'b0, 8'h00, 6, n);
    exp = rx_q.pop_front();
    n_checks += 4;
    if (io_ack !== 1'b1)   begin n_errors++; $display("FAIL read_ack got %b want 1", io_ack); end
    if (n != 2)            begin n_errors++; $display("FAIL read_latency got %0d want 2", n); end
    if (io_rdata !== exp)  begin n_errors++; $display("FAIL read_data got %h want %h", io_rdata, exp); end
    if (rx_level !== 5'd0) begin n_errors++; $display("FAIL read_rxl_post got %0d want 0", rx_level); end
    core_release(dr);
    n_checks++;
    if (dr !== 1'b1) begin n_errors++; $display("FAIL read_ack_drop got %b want 1", dr); end
  endtask

  task automatic test_write;
    int n; logic dr; logic [7:0] exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_xfer(1'b1, 8'h55, 6, n);
      n_checks++;
      if (io_ack !== 1'b1) begin n_errors++; $display("FAIL write_ack[%0d] got %b want 1", i, io_ack); end
      else tx_q.push_back(8'h55);
      core_release(dr);
    end
    n_checks++;
    if (tx_level !== 5'd3) begin n_errors++; $display("FAIL write_txl got %0d want 3", tx_level); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = tx_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        n_errors++; $display("FAIL write_drain[%0d] got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_level !== 5'd0 || tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL write_empty got lvl=%0d v=%b want 0 0", tx_level, tx_valid);
    end
  endtask

  task automatic test_read_stall;
    logic seen; logic dr; logic [7:0] exp;
    @(negedge clk);
    io_req = 1'b1;
    io_dir = 1'b0;
    seen   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (io_ack) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL stall_ack got %b want 0", seen); end
    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    rx_q.push_back(8'h7E);
    @(negedge clk);
    rx_valid = 1'b0;
    n_checks++;
    if (io_ack !== 1'b0) begin n_errors++; $display("FAIL stall_ack_at_push got %b want 0", io_ack); end
    @(negedge clk);
    exp = rx_q.pop_front();
    n_checks += 2;
    if (io_ack !== 1'b1)  begin n_errors++; $display("FAIL stall_ack_after got %b want 1", io_ack); end
    if (io_rdata !== exp) begin n_errors++; $display("FAIL stall_data got %h want %h", io_rdata, exp); end
    core_release(dr);
  endtask

  task automatic test_tx_full;
    int n; logic dr; logic seen; logic [7:0] exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      core_xfer(1'b1, 8'hA0 + 8'(i), 6, n);
      n_checks++;
      if (io_ack !== 1'b1) begin n_errors++; $display("FAIL fill_ack[%0d] got %b want 1", i, io_ack); end
      else tx_q.push_back(8'hA0 + 8'(i));
      core_release(dr);
    end
    n_checks += 2;
    if (tx_level !== 5'd16) begin n_errors++; $display("FAIL full_txl got %0d want 16", tx_level); end
    if (rx_ready !== 1'b1)  begin n_errors++; $display("FAIL full_rxr got %b want 1", rx_ready); end
    @(negedge clk);
    io_req   = 1'b1;
    io_dir   = 1'b1;
    io_wdata = 8'hEE;
    seen     = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (io_ack) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL full_stall got %b want 0", seen); end
    exp = tx_q.pop_front();
    n_checks++;
    if (tx_data !== exp) begin n_errors++; $display("FAIL full_pop_head got %h want %h", tx_data, exp); end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    n = 0;
    while (!io_ack && n < 4) begin
      @(negedge clk);
      n++;
    end
    n_checks += 2;
    if (io_ack !== 1'b1) begin n_errors++; $display("FAIL full_unstall got %b want 1", io_ack); end
    else tx_q.push_back(8'hEE);
    if (tx_level !== 5'd16) begin n_errors++; $display("FAIL full_txl_refill got %0d want 16", tx_level); end
    core_release(dr);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hXX;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        n_errors++; $display("FAIL wrap_drain[%0d] got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_level !== 5'd0) begin n_errors++; $display("FAIL wrap_txl got %0d want 0", tx_level); end
  endtask

  task automatic test_ack_delay;
    int n; logic [7:0] exp;
    @(negedge clk);
    d_rxv = 1'b1;
    d_rxd = 8'h33;
    d_q.push_back(8'h33);
    @(negedge clk);
    d_rxd = 8'h34;
    d_q.push_back(8'h34);
    @(negedge clk);
    d_rxv = 1'b0;
    d_req = 1'b1;
    d_dir = 1'b0;
    n = 0;
    while (!d_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    exp = d_q.pop_front();
    n_checks += 3;
    if (d_ack !== 1'b1)  begin n_errors++; $display("FAIL dly_ack got %b want 1", d_ack); end
    if (n != 5)          begin n_errors++; $display("FAIL dly_latency got %0d want 5", n); end
    if (d_rdata !== exp) begin n_errors++; $display("FAIL dly_data got %h want %h", d_rdata, exp); end
    repeat (10) @(negedge clk);
    n_checks += 3;
    if (d_ack !== 1'b1)  begin n_errors++; $display("FAIL dly_hold_ack got %b want 1", d_ack); end
    if (d_rxl !== 5'd1)  begin n_errors++; $display("FAIL dly_one_pop got %0d want 1", d_rxl); end
    if (d_rdata !== exp) begin n_errors++; $display("FAIL dly_hold_data got %h want %h", d_rdata, exp); end
    d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_ack !== 1'b0) begin n_errors++; $display("FAIL dly_ack_drop got %b want 0", d_ack); end
  endtask

`ifdef BF_IO_EOF_EN
  task automatic test_eof;
    int n; logic dr; logic [7:0] exp;
    rx_eof = 1'b1;
    core_xfer(1'b0, 8'h00, 6, n);
    n_checks += 4;
    if (io_ack !== 1'b1)   begin n_errors++; $display("FAIL eof_ack got %b want 1", io_ack); end
    if (n != 2)            begin n_errors++; $display("FAIL eof_latency got %0d want 2", n); end
    if (io_rdata !== 8'h0) begin n_errors++; $display("FAIL eof_data got %h want 00", io_rdata); end
    if (rx_level !== 5'd0) begin n_errors++; $display("FAIL eof_rxl got %0d want 0", rx_level); end
    core_release(dr);
    host_push(8'h5A);
    core_xfer(1'b0, 8'h00, 6, n);
    exp = rx_q.pop_front();
    n_checks++;
    if (io_rdata !== exp) begin n_errors++; $display("FAIL eof_priority got %h want %h", io_rdata, exp); end
    core_release(dr);
    rx_eof = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    int n; logic [7:0] exp;
    host_push(8'h10);
    core_xfer(1'b0, 8'h00, 6, n);
    exp = rx_q.pop_front();
    n_checks++;
    if (io_ack !== 1'b1 || io_rdata !== exp) begin
      n_errors++; $display("FAIL mid_pre got ack=%b %h want ack=1 %h", io_ack, io_rdata, exp);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (io_ack !== 1'b0)   begin n_errors++; $display("FAIL mid_rst_ack got %b want 0", io_ack); end
    if (io_rdata !== 8'h0) begin n_errors++; $display("FAIL mid_rst_data got %h want 00", io_rdata); end
    io_req = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; io_req = 1'b0; io_dir = 1'b0; io_wdata = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    d_req = 1'b0; d_dir = 1'b0; d_wdata = 8'h00; d_rxv = 1'b0; d_rxd = 8'h00; d_txr = 1'b0;
`ifdef BF_IO_EOF_EN
    rx_eof = 1'b0; d_rx_eof = 1'b0;
`endif
    test_reset();
    test_read();
    test_write();
    test_read_stall();
    test_tx_full();
    test_ack_delay();
`ifdef BF_IO_EOF_EN
    test_eof();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
